// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the sram-like request arbiter
// Contents: src_id_t (which CPU side issued a request), arb_state_t (arbiter FSM),
//           SIZE_* encodings of the sram-like size field.
package sram_arb_pkg;

  typedef enum logic [0:0] {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_id_t;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arb_if.sv
// rtl/sram_req_arb_if.sv - one sram-like request/response port
// Signals: req/wr/size/addr/wstrb/wdata travel master -> slave;
//          addr_ok/data_ok/rdata travel slave -> master.
// Modports: master (issues requests), slave (accepts requests).
interface sram_req_arb_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/src_id_fifo.sv
// rtl/src_id_fifo.sv - in-order FIFO of source IDs for outstanding requests
// Ports: clk, reset (async, active-high); push/push_id write the tail; pop drops the head;
//        full, empty, head (source ID of the oldest outstanding request).
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module src_id_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  src_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output src_id_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  src_id_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arb.sv
// rtl/sram_req_arb.sv - merges instruction and data sram-like ports onto one master port
// Ports: clk, reset (async, active-high); inst/data (slave side of the CPU ports);
//        m (master port toward the bridge); busy (requests outstanding);
//        err_spurious (sticky: response arrived with nothing outstanding).
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise fixed priority by D_PRIO.
module sram_req_arb
  import sram_arb_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter bit D_PRIO      = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  sram_req_arb_if.slave   inst,
  sram_req_arb_if.slave   data,
  sram_req_arb_if.master  m,
  output logic            busy,
  output logic            err_spurious
);

  arb_state_t state, state_nxt;
  src_id_t    hold_src;
  src_id_t    sel;
  src_id_t    head;
  logic       sel_req;
  logic       m_req_c;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

`ifdef ARB_RR_EN
  src_id_t    last_grant;
`endif

  // Grant selection: frozen in HOLD so the request stays stable until accepted.
  always_comb begin
    sel = SRC_D;
    if (state == ARB_HOLD) begin
      sel = hold_src;
    end else if (inst.req && data.req) begin
`ifdef ARB_RR_EN
      sel = (last_grant == SRC_I) ? SRC_D : SRC_I;
`else
      sel = D_PRIO ? SRC_D : SRC_I;
`endif
    end else if (inst.req) begin
      sel = SRC_I;
    end
  end

  assign sel_req = (sel == SRC_D) ? data.req : inst.req;
  // HOLD is only entered when not full and the count cannot grow there,
  // so the full check only matters in IDLE. Full uses the registered count,
  // so a same-cycle pop never opens a push slot.
  assign m_req_c = !reset && sel_req && ((state == ARB_HOLD) || !fifo_full);
  assign push    = m_req_c && m.addr_ok;
  assign pop     = !reset && m.data_ok && !fifo_empty;

  src_id_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      hold_src <= SRC_I;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE) hold_src <= sel;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= D_PRIO ? SRC_I : SRC_D;
    end else if (push) begin
      last_grant <= sel;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_spurious <= 1'b0;
    end else if (m.data_ok && fifo_empty) begin
      err_spurious <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (m_req_c && !m.addr_ok) state_nxt = ARB_HOLD;
      // Leave HOLD on acceptance, or when the granted side withdrew its request.
      ARB_HOLD: if (!m_req_c || m.addr_ok) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    m.req   = m_req_c;
    m.wr    = 1'b0;
    m.size  = '0;
    m.addr  = '0;
    m.wstrb = '0;
    m.wdata = '0;
    if (m_req_c) begin
      if (sel == SRC_D) begin
        m.wr    = data.wr;
        m.size  = data.size;
        m.addr  = data.addr;
        m.wstrb = data.wstrb;
        m.wdata = data.wdata;
      end else begin
        m.wr    = inst.wr;
        m.size  = inst.size;
        m.addr  = inst.addr;
        m.wstrb = inst.wstrb;
        m.wdata = inst.wdata;
      end
    end
    inst.addr_ok = push && (sel == SRC_I);
    data.addr_ok = push && (sel == SRC_D);
    inst.data_ok = pop && (head == SRC_I);
    data.data_ok = pop && (head == SRC_D);
    inst.rdata   = reset ? '0 : m.rdata;
    data.rdata   = reset ? '0 : m.rdata;
    busy         = !reset && !fifo_empty;
  end

endmodule

// File: tb/tb_sram_req_arb.sv
// tb/tb_sram_req_arb.sv - self-checking bench for sram_req_arb
module tb_sram_req_arb;
  localparam int OUT    = 4;
  localparam bit D_PRIO = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, err_spurious;
  int   vectors = 0;
  int   miscompares = 0;

  sram_req_arb_if inst_if ();
  sram_req_arb_if data_if ();
  sram_req_arb_if m_if ();

  sram_req_arb #(.OUTSTANDING(OUT), .D_PRIO(D_PRIO)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst         (inst_if),
    .data         (data_if),
    .m            (m_if),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of issuing sides, plus the side whose request is waiting.
  bit q[$];
  bit held_v, held_s, err_m, last_m;

  always @(negedge clk) begin : compare
    bit ir, dr, full, mreq, sel, acc, ido, ddo;
    #2;
    if (reset) begin
      chk("rst_m_req", m_if.req, 0);
      chk("rst_i_addr_ok", inst_if.addr_ok, 0);
      chk("rst_d_addr_ok", data_if.addr_ok, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_spurious, 0);
      q.delete();
      held_v = 0;
      err_m  = 0;
      last_m = D_PRIO ? 1'b0 : 1'b1;
    end else begin
      ir = inst_if.req;
      dr = data_if.req;
      full = (q.size() == OUT);
      sel = 0;
      mreq = 0;
      if (held_v) begin
        sel = held_s;
        mreq = sel ? dr : ir;
      end else if (!full && (ir || dr)) begin
        mreq = 1;
`ifdef ARB_RR_EN
        sel = (ir && dr) ? !last_m : dr;
`else
        sel = (ir && dr) ? D_PRIO : dr;
`endif
      end
      acc = mreq && m_if.addr_ok;
      chk("m_req", m_if.req, mreq);
      if (mreq) begin
        chk("m_addr", m_if.addr, sel ? data_if.addr : inst_if.addr);
        chk("m_wdata", m_if.wdata, sel ? data_if.wdata : inst_if.wdata);
        chk("m_ctl", {m_if.wr, m_if.size, m_if.wstrb},
            sel ? {data_if.wr, data_if.size, data_if.wstrb} : {inst_if.wr, inst_if.size, inst_if.wstrb});
      end
      chk("i_addr_ok", inst_if.addr_ok, acc && !sel);
      chk("d_addr_ok", data_if.addr_ok, acc && sel);
      ido = m_if.data_ok && q.size() > 0 && q[0] == 1'b0;
      ddo = m_if.data_ok && q.size() > 0 && q[0] == 1'b1;
      chk("i_data_ok", inst_if.data_ok, ido);
      chk("d_data_ok", data_if.data_ok, ddo);
      chk("i_rdata", inst_if.rdata, m_if.rdata);
      chk("d_rdata", data_if.rdata, m_if.rdata);
      chk("busy", busy, q.size() != 0);
      chk("err_spurious", err_spurious, err_m);
      if (m_if.data_ok) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1;
      end
      if (acc) begin
        q.push_back(sel);
        last_m = sel;
        held_v = 0;
      end else if (mreq) begin
        held_v = 1;
        held_s = sel;
      end else begin
        held_v = 0;
      end
    end
  end

  task automatic idle_inputs();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.addr = 0; inst_if.wstrb = 4'hf; inst_if.wdata = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.addr = 0; data_if.wstrb = 4'hf; data_if.wdata = 0;
    m_if.addr_ok = 0; m_if.data_ok = 0; m_if.rdata = 0;
  endtask

  initial begin
    idle_inputs();
    #1 reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;

    // 1: lone data request accepted immediately, then its response.
    @(negedge clk);
    data_if.req = 1; data_if.addr = 32'h1C00_0004; m_if.addr_ok = 1;
    #1 chk("t1_d_addr_ok", data_if.addr_ok, 1);
    chk("t1_i_addr_ok", inst_if.addr_ok, 0);
    chk("t1_m_addr", m_if.addr, 32'h1C00_0004);
    @(negedge clk);
    data_if.req = 0; m_if.addr_ok = 0;
    #1 chk("t1_busy", busy, 1);
    @(negedge clk);
    m_if.data_ok = 1; m_if.rdata = 32'hDEAD_BEEF;
    #1 chk("t1_d_data_ok", data_if.data_ok, 1);
    chk("t1_d_rdata", data_if.rdata, 32'hDEAD_BEEF);
    chk("t1_i_data_ok", inst_if.data_ok, 0);
    @(negedge clk);
    m_if.data_ok = 0;
    #1 chk("t1_idle", busy, 0);

    // 2: both request, downstream stalls; data side is held (fixed priority), then inst follows.
    @(negedge clk);
    data_if.req = 1; data_if.addr = 32'h2000_0000;
    inst_if.req = 1;
    for (int k = 0; k < 3; k++) begin
      inst_if.addr = 32'h3000_0000 + 32'(k * 4);
      #1;
`ifndef ARB_RR_EN
      chk("t2_hold_addr", m_if.addr, 32'h2000_0000);
`endif
      chk("t2_no_accept", {inst_if.addr_ok, data_if.addr_ok}, 0);
      @(negedge clk);
    end
    m_if.addr_ok = 1;
`ifndef ARB_RR_EN
    #1 chk("t2_d_accept", data_if.addr_ok, 1);
    @(negedge clk);
    data_if.req = 0;
    #1 chk("t2_i_next", inst_if.addr_ok, 1);
    chk("t2_i_addr", m_if.addr, 32'h3000_0008);
`else
    @(negedge clk);
    inst_if.req = 0;
`endif
    @(negedge clk);
    inst_if.req = 0; data_if.req = 0; m_if.addr_ok = 0;
    m_if.data_ok = 1;
`ifndef ARB_RR_EN
    #1 chk("t2_resp0_d", data_if.data_ok, 1);
`endif
    @(negedge clk);
`ifndef ARB_RR_EN
    #1 chk("t2_resp1_i", inst_if.data_ok, 1);
`endif
    @(negedge clk);
    m_if.data_ok = 0;

    // 3: fill with four inst reads, then full behaviour around a pop.
    @(negedge clk);
    inst_if.req = 1; m_if.addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      inst_if.addr = 32'h100 + 32'(k * 4);
      #1 chk("t3_fill", inst_if.addr_ok, 1);
      @(negedge clk);
    end
    #1 chk("t3_full_m_req", m_if.req, 0);
    chk("t3_full_addr_ok", inst_if.addr_ok, 0);
    @(negedge clk);
    m_if.data_ok = 1;
    #1 chk("t3_pop_no_accept", inst_if.addr_ok, 0);
    chk("t3_pop_data_ok", inst_if.data_ok, 1);
    @(negedge clk);
    m_if.data_ok = 0;
    #1 chk("t3_accept_after_pop", inst_if.addr_ok, 1);
    @(negedge clk);
    #1 chk("t3_full_again", m_if.req, 0);
    @(negedge clk);
    inst_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_drain", inst_if.data_ok, 1);
      @(negedge clk);
    end
    m_if.data_ok = 0;

    // 4: interleaved I, D, I, D, twice, so the pointers wrap.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        inst_if.req = (k % 2 == 0); data_if.req = (k % 2 == 1); m_if.addr_ok = 1;
        inst_if.addr = 32'h4000 + 32'(k); data_if.addr = 32'h5000 + 32'(k);
        #1 chk("t4_accept", {inst_if.addr_ok, data_if.addr_ok}, (k % 2 == 0) ? 2 : 1);
      end
      @(negedge clk);
      inst_if.req = 0; data_if.req = 0; m_if.addr_ok = 0;
      for (int k = 0; k < 4; k++) begin
        m_if.data_ok = 1; m_if.rdata = 32'(k);
        #1 chk("t4_order", {inst_if.data_ok, data_if.data_ok}, (k % 2 == 0) ? 2 : 1);
        @(negedge clk);
      end
      m_if.data_ok = 0;
    end

    // 5: spurious response, then reset with three outstanding.
    @(negedge clk);
    m_if.data_ok = 1;
    #1 chk("t5_no_data_ok", {inst_if.data_ok, data_if.data_ok}, 0);
    @(negedge clk);
    m_if.data_ok = 0;
    #1 chk("t5_err_set", err_spurious, 1);
    @(negedge clk);
    #1 chk("t5_err_sticky", err_spurious, 1);
    @(negedge clk);
    data_if.req = 1; m_if.addr_ok = 1;
    repeat (3) @(negedge clk);
    #1 chk("t5_busy_before", busy, 1);
    reset = 1;
    #1 chk("t5_rst_busy", busy, 0);
    chk("t5_rst_m_req", m_if.req, 0);
    chk("t5_rst_addr_ok", data_if.addr_ok, 0);
    chk("t5_rst_err", err_spurious, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    idle_inputs();

    // 6: both sides requesting continuously with immediate acceptance.
    @(negedge clk);
    inst_if.req = 1; data_if.req = 1; m_if.addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      #1 chk("t6_rr", data_if.addr_ok, (k % 2 == 0));
`else
      #1 chk("t6_fixed", data_if.addr_ok, 1);
`endif
      @(negedge clk);
    end
    inst_if.req = 0; data_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
    repeat (4) @(negedge clk);
    m_if.data_ok = 0;

    // Random traffic checked cycle by cycle by the model.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      inst_if.req = ($urandom_range(0, 99) < 60);
      inst_if.wr = 1'($urandom); inst_if.size = 2'($urandom_range(0, 2));
      inst_if.addr = $urandom; inst_if.wstrb = 4'($urandom); inst_if.wdata = $urandom;
      data_if.req = ($urandom_range(0, 99) < 60);
      data_if.wr = 1'($urandom); data_if.size = 2'($urandom_range(0, 2));
      data_if.addr = $urandom; data_if.wstrb = 4'($urandom); data_if.wdata = $urandom;
      m_if.addr_ok = 1'($urandom);
      m_if.data_ok = ($urandom_range(0, 99) < 40);
      m_if.rdata = $urandom;
    end
    @(negedge clk);
    reset = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
